// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3.
// Emits WIDTH-cycle results with overflow flag and leading-zero mask.
module bcd_converter_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     nz_mask
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_shift;
  logic [BW-1:0]     r_work;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf_work;
  logic [BW-1:0]     w_corr;
  logic [BW-1:0]     w_work_nxt;
  logic              w_ovf_nxt;
  logic [DIGITS-1:0] w_nz;
  logic              w_accept;
  logic              w_last;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_state == S_CONVERT) &&
                    (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_CONVERT;
      end
      S_CONVERT: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Add-3 correction applied to every digit in parallel
  always_comb begin
    w_corr = r_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_work[4*i +: 4] >= 4'd5)
        w_corr[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
    end
  end

  assign w_work_nxt = {w_corr[BW-2:0], r_shift[WIDTH-1]};
  assign w_ovf_nxt  = r_ovf_work | w_corr[BW-1];

  always_comb begin
    logic v_any;
    v_any = 1'b0;
    w_nz  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_any   = v_any | (|w_work_nxt[4*i +: 4]);
      w_nz[i] = v_any;
    end
    w_nz[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf_work <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
      nz_mask    <= DIGITS'(1);
    end else if (w_accept) begin
      r_shift    <= value;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf_work <= 1'b0;
    end else if (r_state == S_CONVERT) begin
      r_shift    <= r_shift << 1;
      r_work     <= w_work_nxt;
      r_ovf_work <= w_ovf_nxt;
      r_cnt      <= r_cnt + CW'(1);
      if (w_last) begin
        bcd     <= w_work_nxt;
        ovf     <= w_ovf_nxt;
        nz_mask <= w_nz;
      end
    end
  end

endmodule
